// File: rtl/seg_scan_pkg.sv
// -----------------------------------------------------------------------------
// seg_scan_pkg
// Shared definitions for the segment-bar scan scheduler:
//   - scan_state_e : FSM state encoding (SCAN_IDLE, SCAN_LATCH, SCAN_SHOW,
//                    SCAN_BLANK; SCAN_BLANK is only reachable when the design
//                    is built with SEG_SCAN_BLANK_EN defined)
//   - DEF_*        : default parameter values for the scheduler
//   - BRIGHT_ALL_ONES : all-ones brightness code, truncated to PWM_W by users
//   - idx_width()  : channel index width, never less than 1 bit
// No ports (package).
// -----------------------------------------------------------------------------
package seg_scan_pkg;

    typedef enum logic [1:0] {
        SCAN_IDLE  = 2'd0,
        SCAN_LATCH = 2'd1,
        SCAN_SHOW  = 2'd2,
        SCAN_BLANK = 2'd3
    } scan_state_e;

    localparam int DEF_CHANNELS     = 2;
    localparam int DEF_SEG_W        = 10;
    localparam int DEF_DWELL_W      = 16;
    localparam int DEF_PWM_W        = 4;
    localparam int DEF_BLANK_CYCLES = 8;

    // Brightness code meaning "always on"; users cast it down to PWM_W bits.
    localparam logic [31:0] BRIGHT_ALL_ONES = 32'hFFFF_FFFF;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seg_scan_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin finder. Starting at cur_i+1 (mod CHANNELS) it
// returns the first index whose valid bit is set. The current index is only
// returned when it is the sole valid channel (it is the last one searched).
// Ports:
//   ch_valid_i [CHANNELS]  request bits
//   cur_i      [IDX_W]     index currently selected
//   next_o     [IDX_W]     chosen index (cur_i when nothing is valid)
//   found_o                at least one channel is valid
//   wrap_o                 chosen index <= cur_i, i.e. the round has wrapped
// -----------------------------------------------------------------------------
module rr_pick
    import seg_scan_pkg::*;
#(
    parameter  int CHANNELS = DEF_CHANNELS,
    localparam int IDX_W    = idx_width(CHANNELS)
) (
    input  logic [CHANNELS-1:0] ch_valid_i,
    input  logic [IDX_W-1:0]    cur_i,
    output logic [IDX_W-1:0]    next_o,
    output logic                found_o,
    output logic                wrap_o
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    always_comb begin
        next_o   = cur_i;
        found_o  = 1'b0;
        wrap_o   = 1'b0;
        cand     = 0;
        cand_idx = '0;
        // off runs 1..CHANNELS so the current index is visited last.
        for (int off = 1; off <= CHANNELS; off++) begin
            cand     = (int'(cur_i) + off) % CHANNELS;
            cand_idx = IDX_W'(cand);
            if (!found_o && ch_valid_i[cand_idx]) begin
                found_o = 1'b1;
                next_o  = cand_idx;
                wrap_o  = (cand <= int'(cur_i));
            end
        end
    end

endmodule

// File: rtl/seg_scan_sched.sv
// -----------------------------------------------------------------------------
// seg_scan_sched
// Time-multiplexes one SEG_W-wide segment bar between CHANNELS sources.
// Round-robin over requesting channels; each slot is one LATCH cycle (pattern
// and dwell captured) followed by max(dwell,1) SHOW cycles with the pattern
// gated by a brightness PWM. All outputs are registered.
//
// Optional feature: define SEG_SCAN_BLANK_EN to insert BLANK_CYCLES cycles of
// dark output (BLANK state) after every SHOW window for anti-ghosting.
//
// Ports:
//   clk          system clock, posedge
//   reset_n      synchronous active-low reset
//   ch_valid     [CHANNELS]        channel i requests display time
//   ch_segs      [CHANNELS*SEG_W]  channel i pattern at [i*SEG_W +: SEG_W]
//   dwell        [DWELL_W]         SHOW length in cycles, 0 behaves as 1
//   bright       [PWM_W]           PWM duty, all-ones = always on, 0 = off
//   segs         [SEG_W]           segment drive
//   ch_sel       [IDX_W]           index of the channel being shown
//   frame_start                    one-cycle pulse when a new round begins
// -----------------------------------------------------------------------------
module seg_scan_sched
    import seg_scan_pkg::*;
#(
    parameter  int CHANNELS     = DEF_CHANNELS,
    parameter  int SEG_W        = DEF_SEG_W,
    parameter  int DWELL_W      = DEF_DWELL_W,
    parameter  int PWM_W        = DEF_PWM_W,
    parameter  int BLANK_CYCLES = DEF_BLANK_CYCLES,
    localparam int IDX_W        = idx_width(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [CHANNELS-1:0]       ch_valid,
    input  logic [CHANNELS*SEG_W-1:0] ch_segs,
    input  logic [DWELL_W-1:0]        dwell,
    input  logic [PWM_W-1:0]          bright,
    output logic [SEG_W-1:0]          segs,
    output logic [IDX_W-1:0]          ch_sel,
    output logic                      frame_start
);

    localparam logic [PWM_W-1:0] BRIGHT_FULL = PWM_W'(BRIGHT_ALL_ONES);

    scan_state_e        state_q, state_d;
    logic [SEG_W-1:0]   shadow_q, shadow_d;
    logic [SEG_W-1:0]   segs_q, segs_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [IDX_W-1:0]   ch_sel_q, ch_sel_d;
    logic               frame_start_q, frame_start_d;
    logic [PWM_W-1:0]   pwm_cnt_q, pwm_cnt_d;

    logic               pwm_on;
    logic [SEG_W-1:0]   sel_segs;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_found;
    logic               pick_wrap;
    logic               slot_end;

`ifdef SEG_SCAN_BLANK_EN
    localparam int BLANK_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    logic [BLANK_W-1:0] blank_cnt_q, blank_cnt_d;
`else
    wire unused_blank_cycles = (BLANK_CYCLES != 0);
`endif

    rr_pick #(
        .CHANNELS (CHANNELS)
    ) u_rr_pick (
        .ch_valid_i (ch_valid),
        .cur_i      (ch_sel_q),
        .next_o     (pick_idx),
        .found_o    (pick_found),
        .wrap_o     (pick_wrap)
    );

    // Pattern of the channel chosen at the previous arbitration.
    always_comb begin
        sel_segs = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_sel_q == IDX_W'(i)) begin
                sel_segs = ch_segs[i*SEG_W +: SEG_W];
            end
        end
    end

    // The gate is evaluated against the counter value that will be current
    // while the registered segs value is on the pins, keeping them aligned.
    assign pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    assign pwm_on    = (bright == BRIGHT_FULL) || (pwm_cnt_d < bright);

    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        dwell_cnt_d   = dwell_cnt_q;
        ch_sel_d      = ch_sel_q;
        frame_start_d = 1'b0;
        segs_d        = '0;
        slot_end      = 1'b0;
`ifdef SEG_SCAN_BLANK_EN
        blank_cnt_d   = blank_cnt_q;
`endif

        case (state_q)
            SCAN_IDLE: begin
                if (pick_found) begin
                    state_d       = SCAN_LATCH;
                    ch_sel_d      = pick_idx;
                    frame_start_d = 1'b1;
                end
            end

            SCAN_LATCH: begin
                shadow_d    = sel_segs;
                dwell_cnt_d = (dwell == '0) ? DWELL_W'(1) : dwell;
                segs_d      = sel_segs & {SEG_W{pwm_on}};
                state_d     = SCAN_SHOW;
            end

            SCAN_SHOW: begin
                dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                if (dwell_cnt_q <= DWELL_W'(1)) begin
`ifdef SEG_SCAN_BLANK_EN
                    state_d     = SCAN_BLANK;
                    blank_cnt_d = BLANK_W'(BLANK_CYCLES);
`else
                    slot_end    = 1'b1;
`endif
                end else begin
                    segs_d = shadow_q & {SEG_W{pwm_on}};
                end
            end

`ifdef SEG_SCAN_BLANK_EN
            SCAN_BLANK: begin
                if (blank_cnt_q <= BLANK_W'(1)) begin
                    slot_end = 1'b1;
                end else begin
                    blank_cnt_d = blank_cnt_q - BLANK_W'(1);
                end
            end
`endif

            default: begin
                state_d = SCAN_IDLE;
            end
        endcase

        // End of a slot: hand over to the next requester, or go dark.
        if (slot_end) begin
            if (pick_found) begin
                state_d       = SCAN_LATCH;
                ch_sel_d      = pick_idx;
                frame_start_d = pick_wrap;
            end else begin
                state_d       = SCAN_IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= SCAN_IDLE;
            shadow_q      <= '0;
            segs_q        <= '0;
            dwell_cnt_q   <= '0;
            ch_sel_q      <= IDX_W'(CHANNELS - 1);
            frame_start_q <= 1'b0;
            pwm_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            segs_q        <= segs_d;
            dwell_cnt_q   <= dwell_cnt_d;
            ch_sel_q      <= ch_sel_d;
            frame_start_q <= frame_start_d;
            pwm_cnt_q     <= pwm_cnt_d;
        end
    end

`ifdef SEG_SCAN_BLANK_EN
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            blank_cnt_q <= '0;
        end else begin
            blank_cnt_q <= blank_cnt_d;
        end
    end
`endif

    assign segs        = segs_q;
    assign ch_sel      = ch_sel_q;
    assign frame_start = frame_start_q;

endmodule

// File: doc/seg_scan_sched.md
# seg_scan_sched

Time-multiplexing scheduler sharing the single 10-segment bar output between several value sources: encoder position, a status pattern, and so on. Each cycle of its schedule, it does the following:
- picks the next requesting channel round-robin;
- latches that channel's segment pattern and holds it for a programmable dwell;
- gates the output with a brightness PWM.

It sits between the value-to-segment encoders and the `segs` pins, clocked from the fast board clock.

## Interface
- `CHANNELS`, 2 — number of requesting sources, 2..8
- `SEG_W`, 10 — segment count per pattern
- `DWELL_W`, 16 — width of the dwell length input
- `PWM_W`, 4 — brightness resolution
- `BLANK_CYCLES`, 8 — inter-channel blanking length; used only with `SEG_SCAN_BLANK_EN`
- `clk`  in  1  — system clock; all logic on posedge
- `reset_n`  in  1  — synchronous, active-low reset
- `ch_valid`  in  CHANNELS  — channel i requests display time
- `ch_segs`  in  CHANNELS*SEG_W  — channel i pattern at bits [i*SEG_W +: SEG_W]
- `dwell`  in  DWELL_W  — SHOW length in clk cycles; 0 treated as 1
- `bright`  in  PWM_W  — duty: on when `pwm_cnt < bright`; all-ones = always on; 0 = always off
- `segs`  out  SEG_W  — registered segment drive
- `ch_sel`  out  max(1,$clog2(CHANNELS))  — index of the channel being shown
- `frame_start`  out  1  — one-cycle pulse when the schedule wraps to a new round

## Operation
- FSM states: IDLE, LATCH, SHOW, BLANK. BLANK exists only with the macro.
- **IDLE**
  - `segs`=0.
  - If any `ch_valid`: pick the lowest valid index above `ch_sel`, wrapping; go to LATCH.
- **LATCH** (1 cycle)
  - Copy the selected channel's pattern into the shadow register.
  - Load the dwell counter with max(`dwell`,1).
  - Update `ch_sel`; `segs`=0.
  - `frame_start`=1 if the selected index ≤ previous `ch_sel`, or on entry from IDLE.
- **SHOW**
  - `segs` = shadow AND pwm_on; the dwell counter decrements.
  - On the cycle the counter reaches 1, go to the next state.
  - Next state with the macro: BLANK.
  - Next state without the macro: arbitrate. Next valid channel → LATCH; none valid → IDLE.
- **Round-robin**
  - Search starts at `ch_sel`+1 modulo CHANNELS.
  - The current channel is re-selected only if it is the only valid one.
- **Dropping `ch_valid` mid-SHOW**
  - Does not abort; the dwell completes with the latched pattern.
  - `ch_segs` changes during SHOW are ignored until the next LATCH.
- **PWM**
  - `pwm_cnt` is a free-running PWM_W-bit counter, wrapping 2^PWM_W−1→0, independent of the FSM.
  - `bright` is sampled every cycle.
- **`dwell`** is sampled only in LATCH.
- **Reset**, valid at any point including mid-SHOW:
  - state=IDLE, `segs`=0, `ch_sel`=CHANNELS−1 so that channel 0 is first, `frame_start`=0.
  - `pwm_cnt`, shadow and dwell counter are all 0.

## Timing
- All outputs are registered.
- A request at cycle t in IDLE gives: arbitration seen at edge t, LATCH in cycle t+1, first SHOW cycle t+2.
- One channel slot = 1 (LATCH) + max(dwell,1) (SHOW) + BLANK_CYCLES (macro only).
- Two always-valid channels, dwell=D, no macro: period 2(D+1) cycles; `frame_start` once per period.
- `segs` is guaranteed 0 during LATCH, BLANK and IDLE. There is no cycle where two channels' data overlap.

## Configuration
- `SEG_SCAN_BLANK_EN` defined:
  - After SHOW, hold `segs`=0 for BLANK_CYCLES cycles in BLANK (anti-ghosting).
  - Then arbitrate exactly as at the end of SHOW.
  - A reset during BLANK goes to IDLE.
- `SEG_SCAN_BLANK_EN` undefined:
  - The BLANK state and its counter are not built.
  - SHOW goes directly to LATCH/IDLE; BLANK_CYCLES is ignored.

## Structure
- Shared package `seg_scan_pkg`:
  - FSM state encoding (`SCAN_IDLE`, `SCAN_LATCH`, `SCAN_SHOW`, `SCAN_BLANK`);
  - default widths;
  - the all-ones brightness constant.
- One sub-module: `rr_pick`, combinational round-robin next-index finder.
  - Inputs: `ch_valid`, current index.
  - Outputs: next index, found flag, wrapped flag.
  - Feeds both LATCH and `frame_start`.

## Test plan
- **Reset/idle:** `reset_n`=0 for 3 cycles, `ch_valid`=0 → `segs`=0, `ch_sel`=CHANNELS−1, `frame_start`=0; the FSM stays IDLE for 100 cycles.
- **Two-channel rotation:** CHANNELS=2, `ch_segs`={10'h3FF,10'h001}, `dwell`=4, `bright`=all-ones, both valid, no macro.
  - `segs` sequence: 0, 001×4, 0, 3FF×4, repeating.
  - `ch_sel` alternates 0,1.
  - `frame_start` pulses every 10 cycles, on the channel 0 LATCH.
- **Skip invalid channel:** CHANNELS=3, only channels 0 and 2 valid → `ch_sel` visits 0,2,0,2 and channel 1 never appears. With only channel 2 valid → `ch_sel` is always 2 and `frame_start` fires on every LATCH.
- **Mid-dwell changes:** change `ch_segs` and drop `ch_valid[0]` in the 2nd SHOW cycle → the old pattern is held for the remaining dwell, then channel 1 shows with no gap beyond LATCH. Assert `reset_n`=0 in the 3rd SHOW cycle → `segs`=0 on the next edge, then IDLE.
- **PWM:** `bright`=4, PWM_W=4, `dwell`=64, single channel 10'h3FF → within SHOW, `segs`=3FF for exactly 4 of every 16 cycles. `bright`=0 → `segs` always 0.
- **Blanking (macro on):** BLANK_CYCLES=8, `dwell`=4 → exactly 8 zero cycles plus 1 LATCH cycle between consecutive SHOW windows; two-channel period 26 cycles.
